// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the execute ALU: decodes RV32I register and immediate ALU ops,
// reads the register file, and registers {alu_op, operands, rd} while a short rd scoreboard blocks RAW hazards.
module alu_issue_stage #(
    parameter int          HAZARD_DEPTH = 2,
    parameter logic [5:0]  BUBBLE_OP    = 6'd63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        flush,
    input  logic        stall_in,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [5:0]  alu_op,
    output logic [31:0] data_in_1,
    output logic [31:0] data_in_2,
    output logic        issue_valid,
    output logic [4:0]  issue_rd,
    output logic        illegal_instr
);

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic        w_is_r;
    logic        w_legal;
    logic [5:0]  w_op;
    logic [31:0] w_op2;
    logic        w_hazard;
    logic        w_accept;
    logic        w_mark_busy;

    logic [5:0]  r_alu_op;
    logic [31:0] r_data_in_1;
    logic [31:0] r_data_in_2;
    logic        r_issue_valid;
    logic [4:0]  r_issue_rd;
    logic        r_illegal;

    logic [HAZARD_DEPTH-1:0]      r_sb_v;
    logic [HAZARD_DEPTH-1:0][4:0] r_sb_rd;

    assign w_opcode = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    always_comb begin
        w_is_r  = 1'b0;
        w_legal = 1'b0;
        w_op    = BUBBLE_OP;
        w_op2   = rs2_data;
        case (w_opcode)
            OPC_R: begin
                w_is_r = 1'b1;
                case (w_f3)
                    3'b000: begin
                        if (w_f7 == F7_BASE) begin
                            w_legal = 1'b1;
                            w_op    = 6'd0;
                        end else if (w_f7 == F7_ALT) begin
                            w_legal = 1'b1;
                            w_op    = 6'd1;
                        end
                    end
                    3'b101: begin
                        if (w_f7 == F7_BASE) begin
                            w_legal = 1'b1;
                            w_op    = 6'd6;
                        end else if (w_f7 == F7_ALT) begin
                            w_legal = 1'b1;
                            w_op    = 6'd7;
                        end
                    end
                    default: begin
                        w_legal = (w_f7 == F7_BASE);
                        case (w_f3)
                            3'b001:  w_op = 6'd5;
                            3'b010:  w_op = 6'd8;
                            3'b011:  w_op = 6'd9;
                            3'b100:  w_op = 6'd2;
                            3'b110:  w_op = 6'd3;
                            default: w_op = 6'd4;
                        endcase
                    end
                endcase
                if (!w_legal) begin
                    w_op = BUBBLE_OP;
                end
            end
            OPC_I: begin
                w_op2 = {{20{instr[31]}}, instr[31:20]};
                case (w_f3)
                    3'b000: begin w_legal = 1'b1; w_op = 6'd10; end
                    3'b010: begin w_legal = 1'b1; w_op = 6'd17; end
                    3'b011: begin w_legal = 1'b1; w_op = 6'd18; end
                    3'b100: begin w_legal = 1'b1; w_op = 6'd11; end
                    3'b110: begin w_legal = 1'b1; w_op = 6'd12; end
                    3'b111: begin w_legal = 1'b1; w_op = 6'd13; end
                    3'b001: begin
                        // Shift immediates carry only a 5-bit shamt; the upper imm bits act as funct7.
                        w_op2 = {27'd0, instr[24:20]};
                        if (w_f7 == F7_BASE) begin
                            w_legal = 1'b1;
                            w_op    = 6'd14;
                        end
                    end
                    default: begin
                        w_op2 = {27'd0, instr[24:20]};
                        if (w_f7 == F7_BASE) begin
                            w_legal = 1'b1;
                            w_op    = 6'd15;
                        end else if (w_f7 == F7_ALT) begin
                            w_legal = 1'b1;
                            w_op    = 6'd16;
                        end
                    end
                endcase
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZARD_DEPTH; i++) begin
            if (r_sb_v[i] && (rs1_addr != 5'd0) && (r_sb_rd[i] == rs1_addr)) begin
                w_hazard = 1'b1;
            end
            if (w_is_r && r_sb_v[i] && (rs2_addr != 5'd0) && (r_sb_rd[i] == rs2_addr)) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign instr_ready = !reset && !flush && !stall_in && !w_hazard;
    assign w_accept    = instr_valid && instr_ready;
    assign w_mark_busy = w_accept && w_legal && (w_rd != 5'd0);

    // A flush kills the instruction sitting in the output register, so its entry is
    // dropped as it moves from slot 0 to slot 1; older entries keep aging normally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sb_v  <= '0;
            r_sb_rd <= '0;
        end else if (flush || !stall_in) begin
            r_sb_v[0]  <= w_mark_busy;
            r_sb_rd[0] <= w_rd;
            for (int i = 1; i < HAZARD_DEPTH; i++) begin
                r_sb_v[i]  <= r_sb_v[i-1] && !(flush && (i == 1));
                r_sb_rd[i] <= r_sb_rd[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_alu_op      <= BUBBLE_OP;
            r_data_in_1   <= 32'd0;
            r_data_in_2   <= 32'd0;
            r_issue_valid <= 1'b0;
            r_issue_rd    <= 5'd0;
            r_illegal     <= 1'b0;
        end else if (flush) begin
            r_alu_op      <= BUBBLE_OP;
            r_issue_valid <= 1'b0;
            r_illegal     <= 1'b0;
        end else if (!stall_in) begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_issue_valid <= 1'b1;
                r_alu_op      <= w_op;
                r_data_in_1   <= rs1_data;
                r_data_in_2   <= w_op2;
                r_issue_rd    <= w_rd;
            end else begin
                r_issue_valid <= 1'b0;
                r_alu_op      <= BUBBLE_OP;
            end
        end
    end

    assign alu_op        = r_alu_op;
    assign data_in_1     = r_data_in_1;
    assign data_in_2     = r_data_in_2;
    assign issue_valid   = r_issue_valid;
    assign issue_rd      = r_issue_rd;
    assign illegal_instr = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a modelled register file feeds the DUT, issued instructions
// are checked against an expected queue, and each task covers one behaviour.
module tb_alu_issue_stage;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        flush;
    logic        stall_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [5:0]  alu_op;
    logic [31:0] data_in_1;
    logic [31:0] data_in_2;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        illegal_instr;

    logic [31:0] rf [32];
    logic [74:0] exp_q [$];
    logic        tb_hold;
    int          n_pass;
    int          n_total;

    alu_issue_stage #(.HAZARD_DEPTH(2), .BUBBLE_OP(6'd63)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .flush(flush), .stall_in(stall_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_op(alu_op), .data_in_1(data_in_1), .data_in_2(data_in_2),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .illegal_instr(illegal_instr)
    );

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Outputs only carry a fresh instruction when the previous edge was not a pure stall.
    always @(posedge clock) tb_hold <= stall_in && !flush && !reset;

    always @(negedge clock) begin
        if (issue_valid && !tb_hold) begin
            logic [74:0] e;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_issue: got op=%0d d1=%h d2=%h rd=%0d, want no issue",
                         alu_op, data_in_1, data_in_2, issue_rd);
            end else begin
                e = exp_q.pop_front();
                if ({alu_op, data_in_1, data_in_2, issue_rd} !== e)
                    $display("FAIL issue: got op=%0d d1=%h d2=%h rd=%0d, want op=%0d d1=%h d2=%h rd=%0d",
                             alu_op, data_in_1, data_in_2, issue_rd,
                             e[74:69], e[68:37], e[36:5], e[4:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [5:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, input logic legal, output int waits);
        instr_valid = 1'b1;
        instr       = ins;
        waits       = 0;
        @(negedge clock);
        while (!instr_ready && waits < 20) begin
            @(negedge clock);
            waits++;
        end
        if (!instr_ready) begin
            n_total++;
            $display("FAIL send_timeout: instr %h never accepted after %0d cycles, want acceptance", ins, waits);
        end else if (legal) begin
            exp_q.push_back({op, d1, d2, ins[11:7]});
        end
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; stall_in = 1'b0; instr_valid = 1'b0; instr = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        n_total++; if (alu_op !== 6'd63) $display("FAIL reset_op: got %0d want 63", alu_op); else n_pass++;
        n_total++; if ({data_in_1, data_in_2} !== 64'd0) $display("FAIL reset_data: got %h %h want 0 0", data_in_1, data_in_2); else n_pass++;
        n_total++; if ({issue_valid, issue_rd, illegal_instr} !== 7'd0) $display("FAIL reset_flags: got v=%b rd=%0d ill=%b want 0 0 0", issue_valid, issue_rd, illegal_instr); else n_pass++;
        n_total++; if (instr_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", instr_ready); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (instr_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", instr_ready); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int w;
        instr = enc_r(7'h00, 5'd4, 5'd3, 3'b000, 5'd2);
        #1;
        n_total++; if ({rs1_addr, rs2_addr} !== {5'd3, 5'd4}) $display("FAIL rs_addr: got %0d %0d want 3 4", rs1_addr, rs2_addr); else n_pass++;
        send(enc_i(12'hFFB, 5'd0, 3'b000, 5'd1), 6'd10, 32'd0, 32'hFFFFFFFB, 1'b1, w);
        send(enc_r(7'h00, 5'd4, 5'd3, 3'b000, 5'd2), 6'd0, 32'd7, 32'd9, 1'b1, w);
        n_total++; if (w !== 0) $display("FAIL back_to_back_wait: got %0d stall cycles want 0", w); else n_pass++;
        idle(2);
    endtask

    task automatic test_hazard;
        int w;
        send(enc_i(12'd1, 5'd0, 3'b000, 5'd5), 6'd10, 32'd0, 32'd1, 1'b1, w);
        send(enc_r(7'h20, 5'd5, 5'd5, 3'b000, 5'd6), 6'd1, rf[5], rf[5], 1'b1, w);
        n_total++; if (w !== 2) $display("FAIL raw_stall: got %0d stall cycles want 2", w); else n_pass++;
        idle(3);
    endtask

    task automatic test_decode;
        logic [31:0] t_ins [11];
        logic [5:0]  t_op  [11];
        logic [31:0] t_d1  [11];
        logic [31:0] t_d2  [11];
        logic [31:0] bad   [4];
        int w;
        t_ins[0]  = enc_r(7'h00, 5'd12, 5'd11, 3'b100, 5'd20); t_op[0]  = 6'd2;  t_d2[0]  = rf[12];
        t_ins[1]  = enc_r(7'h20, 5'd12, 5'd11, 3'b101, 5'd20); t_op[1]  = 6'd7;  t_d2[1]  = rf[12];
        t_ins[2]  = enc_r(7'h00, 5'd12, 5'd11, 3'b011, 5'd20); t_op[2]  = 6'd9;  t_d2[2]  = rf[12];
        t_ins[3]  = enc_r(7'h00, 5'd12, 5'd11, 3'b001, 5'd20); t_op[3]  = 6'd5;  t_d2[3]  = rf[12];
        t_ins[4]  = enc_i(12'h0F0, 5'd11, 3'b110, 5'd20);      t_op[4]  = 6'd12; t_d2[4]  = 32'h000000F0;
        t_ins[5]  = enc_i(12'h800, 5'd11, 3'b111, 5'd20);      t_op[5]  = 6'd13; t_d2[5]  = 32'hFFFFF800;
        t_ins[6]  = enc_i({7'h00, 5'd31}, 5'd11, 3'b001, 5'd20); t_op[6] = 6'd14; t_d2[6]  = 32'd31;
        t_ins[7]  = enc_i(12'h7FF, 5'd11, 3'b010, 5'd20);      t_op[7]  = 6'd17; t_d2[7]  = 32'h000007FF;
        t_ins[8]  = enc_i({7'h00, 5'd4}, 5'd11, 3'b101, 5'd20); t_op[8] = 6'd15; t_d2[8]  = 32'd4;
        t_ins[9]  = enc_i({7'h20, 5'd3}, 5'd8, 3'b101, 5'd7);  t_op[9]  = 6'd16; t_d2[9]  = 32'd3;
        t_ins[10] = enc_i(12'hFFF, 5'd8, 3'b011, 5'd9);        t_op[10] = 6'd18; t_d2[10] = 32'hFFFFFFFF;
        for (int i = 0; i < 11; i++) t_d1[i] = (i >= 9) ? rf[8] : rf[11];
        for (int i = 0; i < 11; i++) send(t_ins[i], t_op[i], t_d1[i], t_d2[i], 1'b1, w);
        idle(3);
        bad[0] = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd10);
        bad[1] = {12'd0, 5'd1, 3'b010, 5'd10, 7'b0000011};
        bad[2] = enc_i({7'h20, 5'd1}, 5'd1, 3'b001, 5'd10);
        bad[3] = enc_r(7'h20, 5'd2, 5'd1, 3'b100, 5'd10);
        for (int i = 0; i < 4; i++) begin
            send(bad[i], 6'd0, 32'd0, 32'd0, 1'b0, w);
            n_total++;
            if ({illegal_instr, issue_valid, alu_op} !== {1'b1, 1'b0, 6'd63})
                $display("FAIL illegal_%0d: got ill=%b v=%b op=%0d want ill=1 v=0 op=63", i, illegal_instr, issue_valid, alu_op);
            else n_pass++;
        end
        idle(1);
        n_total++; if (illegal_instr !== 1'b0) $display("FAIL illegal_pulse_end: got %b want 0", illegal_instr); else n_pass++;
    endtask

    task automatic test_stall;
        int w;
        send(enc_i(12'h123, 5'd11, 3'b000, 5'd13), 6'd10, rf[11], 32'h123, 1'b1, w);
        stall_in    = 1'b1;
        instr_valid = 1'b1;
        instr       = enc_i(12'h0F0, 5'd12, 3'b110, 5'd14);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_total++;
            if ({instr_ready, issue_valid, alu_op, data_in_2} !== {1'b0, 1'b1, 6'd10, 32'h123})
                $display("FAIL stall_hold_%0d: got rdy=%b v=%b op=%0d d2=%h want rdy=0 v=1 op=10 d2=123", i, instr_ready, issue_valid, alu_op, data_in_2);
            else n_pass++;
            @(posedge clock);
            #1;
        end
        stall_in = 1'b0;
        send(enc_i(12'h0F0, 5'd12, 3'b110, 5'd14), 6'd12, rf[12], 32'h0F0, 1'b1, w);
        n_total++; if (w !== 0) $display("FAIL stall_resume_wait: got %0d want 0", w); else n_pass++;
        idle(2);
    endtask

    task automatic test_flush;
        int w;
        send(enc_i(12'd2, 5'd0, 3'b000, 5'd15), 6'd10, 32'd0, 32'd2, 1'b1, w);
        flush    = 1'b1;
        stall_in = 1'b1;
        #1;
        n_total++; if (instr_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", instr_ready); else n_pass++;
        @(posedge clock);
        #1;
        n_total++;
        if ({issue_valid, alu_op, illegal_instr} !== {1'b0, 6'd63, 1'b0})
            $display("FAIL flush_kill: got v=%b op=%0d ill=%b want v=0 op=63 ill=0", issue_valid, alu_op, illegal_instr);
        else n_pass++;
        flush    = 1'b0;
        stall_in = 1'b0;
        send(enc_r(7'h00, 5'd15, 5'd15, 3'b000, 5'd16), 6'd0, rf[15], rf[15], 1'b1, w);
        n_total++; if (w !== 0) $display("FAIL flush_no_hazard: got %0d stall cycles want 0", w); else n_pass++;
        idle(3);
    endtask

    task automatic test_reset_mid;
        int w;
        send(enc_i(12'd3, 5'd0, 3'b000, 5'd17), 6'd10, 32'd0, 32'd3, 1'b1, w);
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_total++;
        if ({alu_op, data_in_1, data_in_2, issue_valid, issue_rd, illegal_instr} !== {6'd63, 64'd0, 1'b0, 5'd0, 1'b0})
            $display("FAIL midreset_values: got op=%0d d1=%h d2=%h v=%b rd=%0d ill=%b want 63 0 0 0 0 0",
                     alu_op, data_in_1, data_in_2, issue_valid, issue_rd, illegal_instr);
        else n_pass++;
        reset = 1'b0;
        send(enc_r(7'h00, 5'd17, 5'd17, 3'b000, 5'd18), 6'd0, rf[17], rf[17], 1'b1, w);
        n_total++; if (w !== 0) $display("FAIL midreset_no_stall: got %0d want 0", w); else n_pass++;
        idle(3);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 32; i++) rf[i] = {8'hA5, 8'(i), 8'(i * 3), 8'(i * 7)};
        rf[0] = 32'd0;
        rf[3] = 32'd7;
        rf[4] = 32'd9;
        test_reset;
        test_back_to_back;
        test_hazard;
        test_decode;
        test_stall;
        test_flush;
        test_reset_mid;
        n_total++; if (exp_q.size() !== 0) $display("FAIL queue_drain: got %0d pending want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
